// File: rtl/program_loader.sv
// Framed byte-stream loader for the instruction memory write port.
// Holds the CPU in reset until a checksum-verified image has been written.
module program_loader #(
    parameter int         SIZE      = 64,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter bit         BOOT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHECK, DONE, ERR
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(SIZE);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [31:0] word_q, word_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        acc;
    logic [15:0] cnt_next;

    assign in_ready  = (state_q != WRITE);
    assign acc       = in_valid && in_ready;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        csum_d      = csum_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        cnt_next    = {in_data, count_q[7:0]};

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (acc && in_data == SYNC_BYTE) begin
                    state_d    = CNT_LO;
                    csum_d     = 8'd0;
                    word_idx_d = 16'd0;
                    byte_idx_d = 2'd0;
                    cpu_rst_d  = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            CNT_LO: begin
                if (acc) begin
                    count_d[7:0] = in_data;
                    state_d      = CNT_HI;
                end
            end
            CNT_HI: begin
                if (acc) begin
                    count_d = cnt_next;
                    if (cnt_next > MAX_CNT) begin
                        state_d = ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else if (cnt_next == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    word_d[8*byte_idx_q +: 8] = in_data;
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Strobe is registered so it lines up with WRITE
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {16'd0, word_idx_q};
                        mem_wdata_d = word_d;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_d == count_q) ? CHECK : DATA;
            end
            CHECK: begin
                if (acc) begin
                    busy_d = 1'b0;
                    if (in_data == csum_q) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= 16'd0;
            word_idx_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            csum_q      <= 8'd0;
            word_q      <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            cpu_rst_q   <= BOOT_HOLD;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed-vector bench for program_loader.
// Writes are logged on the falling edge and compared to hand-computed words.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_rst, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic        b_ready, b_we, b_cpu_rst, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_wdata;

    int errors = 0;
    int checks = 0;
    int ready_low = 0;
    int ready_bad = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  seq[$];

    always #5 clk = ~clk;

    program_loader #(.SIZE(64), .SYNC_BYTE(8'hA5), .BOOT_HOLD(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .err(err)
    );

    program_loader #(.SIZE(64), .SYNC_BYTE(8'hA5), .BOOT_HOLD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .cpu_rst(b_cpu_rst), .busy(b_busy),
        .done(b_done), .err(b_err)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (!in_ready) ready_low++;
        if (in_ready == mem_we) ready_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input int first, input int last, input bit bub);
        for (int i = first; i <= last; i++)
            send_byte(seq[i], bub ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic chk_writes(input string tag, input int n);
        logic [31:0] ea[2];
        logic [31:0] ed[2];
        ea[0] = 32'd0;
        ea[1] = 32'd1;
        ed[0] = 32'h0000_0013;
        ed[1] = 32'h0010_0093;
        chk({tag, "_nwr"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], ea[i]);
            chk($sformatf("%s_data%0d", tag, i), wr_data[i], ed[i]);
        end
    endtask

    task automatic chk_flags(input string tag, input logic d,
                             input logic e, input logic c);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
        chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, c});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk_flags(tag, 1'b0, 1'b0, 1'b1);
        chk({tag, "_b_cpu_rst"}, {31'd0, b_cpu_rst}, 32'd0);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset("rst");

        // Good two-word frame
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        clear_log();
        send_byte(8'hA5, 0);
        chk("t1_busy_cnt", {31'd0, busy}, 32'd1);
        chk("t1_b_cpu_rst", {31'd0, b_cpu_rst}, 32'd1);
        send_seq(1, 10, 1'b0);
        chk("t1_busy_check", {31'd0, busy}, 32'd1);
        send_byte(8'h90, 0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk_flags("t1", 1'b1, 1'b0, 1'b0);
        chk_writes("t1", 2);

        // Same frame, wrong checksum
        clear_log();
        seq[11] = 8'h91;
        send_byte(8'hA5, 0);
        chk_flags("t2_sync", 1'b0, 1'b0, 1'b1);
        send_seq(1, 11, 1'b0);
        chk_flags("t2", 1'b0, 1'b1, 1'b1);
        chk_writes("t2", 2);

        // Oversize count: 0x41 > 64
        clear_log();
        seq = '{8'hA5, 8'h41, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_seq(0, 2, 1'b0);
        chk_flags("t3", 1'b0, 1'b1, 1'b1);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        send_seq(3, 6, 1'b0);
        chk_flags("t3_after", 1'b0, 1'b1, 1'b1);
        chk_writes("t3", 0);

        // Garbage then good frame with bubbles
        clear_log();
        seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00,
                8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_seq(0, 2, 1'b1);
        chk("t4_garbage_err", {31'd0, err}, 32'd1);
        chk("t4_garbage_busy", {31'd0, busy}, 32'd0);
        ready_low = 0;
        ready_bad = 0;
        send_seq(3, 14, 1'b1);
        repeat (2) @(negedge clk);
        chk_flags("t4", 1'b1, 1'b0, 1'b0);
        chk_writes("t4", 2);
        chk("t4_ready_low", ready_low, 32'd2);
        chk("t4_ready_vs_we", ready_bad, 32'd0);

        // Reset after the fifth data byte
        clear_log();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        send_seq(0, 7, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("t5_rst");
        chk_writes("t5_part", 1);
        repeat (3) @(negedge clk);
        chk_writes("t5_idle", 1);
        clear_log();
        send_seq(0, 11, 1'b0);
        chk_flags("t5", 1'b1, 1'b0, 1'b0);
        chk_writes("t5", 2);

        // Zero-count frames
        clear_log();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(0, 3, 1'b0);
        chk_flags("t6_ok", 1'b1, 1'b0, 1'b0);
        seq[3] = 8'h01;
        send_seq(0, 3, 1'b0);
        chk_flags("t6_bad", 1'b0, 1'b1, 1'b1);
        chk_writes("t6", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream (e.g. from a UART receiver) and assembles little-endian 32-bit words.
- Writes words at consecutive word addresses into a writable instruction memory that the CPU reads through a word-indexed asynchronous read port.
- Holds the CPU in reset while a load is in progress and releases it only after a checksum-verified load.
- Frame format: SYNC_BYTE, count_lo, count_hi, 4*count data bytes, one XOR checksum byte.

Parameters:
- SIZE, 64, instruction memory depth in 32-bit words; maximum accepted word count.
- SYNC_BYTE, 8'hA5, frame start marker.
- BOOT_HOLD, 1: cpu_rst stays high after reset until the first successful load. 0: cpu_rst is low in IDLE, so the CPU runs the preloaded image until SYNC_BYTE arrives.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  byte available
- in_data  input  8  byte value
- in_ready  output  1  byte accepted when in_valid && in_ready at posedge clk
- mem_we  output  1  one-cycle write strobe
- mem_addr  output  32  word address; same indexing as the CPU instruction fetch port
- mem_wdata  output  32  word to write
- cpu_rst  output  1  CPU reset request, active-high
- busy  output  1  frame in progress (any state other than IDLE, DONE, ERR)
- done  output  1  last load succeeded
- err  output  1  last load failed

Behaviour:
- Reset: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst=BOOT_HOLD, in_ready=1, word index=0, byte index=0, checksum=0.
- Reset mid-frame: the frame is aborted with no further writes. Words already written stay in memory.
- in_ready=1 in every state except WRITE. Gaps in in_valid are allowed anywhere and the state is held.
- IDLE: bytes other than SYNC_BYTE are dropped. On SYNC_BYTE -> CNT_LO; clear checksum and indices; cpu_rst=1.
- CNT_LO: latch count[7:0] -> CNT_HI.
- CNT_HI: latch count[15:8], then:
  - count > SIZE -> ERR (no writes).
  - count == 0 -> CHECK.
  - otherwise -> DATA.
- DATA: byte b goes to word[8*byte_idx +: 8] (little-endian); checksum ^= b. After byte_idx==3 -> WRITE.
- WRITE: exactly one cycle.
  - mem_we=1, mem_addr=word_idx, mem_wdata=assembled word.
  - word_idx increments.
  - If the new word_idx == count -> CHECK, else -> DATA.
  - mem_we is low in all other cycles.
- CHECK: the accepted byte is compared with checksum. Equal -> DONE, else -> ERR.
- Checksum covers data bytes only. It excludes sync, count and the checksum byte itself.
- DONE: done=1, err=0, cpu_rst=0 (released the cycle after the checksum byte is accepted).
- ERR: err=1, done=0, cpu_rst=1.
- From DONE or ERR:
  - SYNC_BYTE starts a new frame (-> CNT_LO). done and err clear and cpu_rst rises in the same cycle the transition registers.
  - Any other byte is ignored.
- mem_addr and mem_wdata hold their last values between writes.
- All outputs are registered except in_ready, which decodes from state.

Test Plan:
- Stream A5 02 00 | 13 00 00 00 | 93 00 10 00 | 90 -> expect:
  - mem_we pulses twice: addr0=0x00000013, addr1=0x00100093.
  - done=1, err=0, cpu_rst=0.
  - busy high from CNT_LO through CHECK.
- Same stream with final byte 91 -> both words written, then err=1, done=0, cpu_rst stays 1.
- SIZE=64, stream A5 41 00 -> err=1 right after the count_hi byte. mem_we is never asserted and following bytes are ignored until the next A5.
- Leading garbage 00 FF 5A, then test 1's frame with random in_valid bubbles (0-3 idle cycles per byte) -> identical writes and done=1. in_ready=0 exactly in the two WRITE cycles.
- Assert rst for one cycle after the fifth data byte of test 1's frame:
  - Only the addr0 write occurs.
  - After rst, all outputs equal their reset values (cpu_rst=1 with BOOT_HOLD=1).
  - Resending the full frame succeeds.
- Frame A5 00 00 00 -> done=1 with no writes. Then A5 00 00 01 -> err=1.
- With BOOT_HOLD=0, after reset cpu_rst=0 until A5 arrives.
